sova_iter_sched: RTL and testbench

Iteration scheduler for the turbo decoder's single SOVA soft-output core (`softout`, 4 trellis steps, 31-bit sign-magnitude outputs). It time-shares that core between the two constituent decoders. For each half-iteration it:
- pulses the core's reset,
- selects the metric bank,
- waits out the core's fixed latency,
- captures the four soft outputs,
- presents them downstream with a valid/ready handshake.

It repeats this for `num_iter` full iterations, then signals done.

---
 rtl/turbo_pkg.sv | 7 +
 rtl/sova_iter_sched.sv | 124 ++++++++++++
 tb/tb_sova_iter_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
// turbo_pkg: shared scheduler states and core timing constants for the turbo decoder
package turbo_pkg;
    localparam int SOFT_W       = 31;
    localparam int CORE_LAT     = 28;
    localparam int CORE_RST_CYC = 2;
    typedef enum logic [2:0] {IDLE, CORE_RST, RUN, CAPTURE, OUT} state_t;
endpackage

// File: rtl/sova_iter_sched.sv
// sova_iter_sched: time-shares one SOVA core between both constituent decoders per half-iteration
module sova_iter_sched #(
    parameter int MAX_ITER = 8,
    parameter int CORE_LAT = turbo_pkg::CORE_LAT,
    parameter int SOFT_W   = turbo_pkg::SOFT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        num_iter,
    input  logic              abort,
    output logic              busy,
    output logic              core_rst_n,
    output logic              dec_sel,
    output logic [3:0]        iter_idx,
    input  logic [SOFT_W-1:0] soft_in1,
    input  logic [SOFT_W-1:0] soft_in2,
    input  logic [SOFT_W-1:0] soft_in3,
    input  logic [SOFT_W-1:0] soft_in4,
    output logic [SOFT_W-1:0] llr_out1,
    output logic [SOFT_W-1:0] llr_out2,
    output logic [SOFT_W-1:0] llr_out3,
    output logic [SOFT_W-1:0] llr_out4,
    output logic [3:0]        hard_bits,
    output logic              llr_valid,
    input  logic              llr_ready,
    output logic              llr_last,
    output logic              done
);
    import turbo_pkg::*;

    localparam int CW = $clog2(CORE_LAT > CORE_RST_CYC ? CORE_LAT : CORE_RST_CYC);
    localparam logic [CW-1:0] LAT_END = CW'(CORE_LAT - 1);
    localparam logic [CW-1:0] RST_END = CW'(CORE_RST_CYC - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    n_lat;
    logic [3:0]    n_eff;
    logic          last_half;

    always_comb begin
        n_eff     = num_iter == 4'd0 ? 4'd1 : (num_iter > 4'(MAX_ITER) ? 4'(MAX_ITER) : num_iter);
        last_half = dec_sel && (iter_idx == n_lat - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            n_lat      <= '0;
            busy       <= 1'b0;
            core_rst_n <= 1'b0;
            dec_sel    <= 1'b0;
            iter_idx   <= '0;
            llr_out1   <= '0;
            llr_out2   <= '0;
            llr_out3   <= '0;
            llr_out4   <= '0;
            hard_bits  <= '0;
            llr_valid  <= 1'b0;
            llr_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state      <= IDLE;
                busy       <= 1'b0;
                core_rst_n <= 1'b0;
                llr_valid  <= 1'b0;
                llr_last   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        state    <= CORE_RST;
                        n_lat    <= n_eff;
                        iter_idx <= '0;
                        dec_sel  <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                    end
                    CORE_RST: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == RST_END) begin
                            state      <= RUN;
                            cnt        <= '0;
                            core_rst_n <= 1'b1;
                        end
                    end
                    RUN: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAT_END) state <= CAPTURE;
                    end
                    CAPTURE: begin
                        llr_out1  <= soft_in1;
                        llr_out2  <= soft_in2;
                        llr_out3  <= soft_in3;
                        llr_out4  <= soft_in4;
                        hard_bits <= {soft_in4[SOFT_W-1], soft_in3[SOFT_W-1], soft_in2[SOFT_W-1], soft_in1[SOFT_W-1]};
                        llr_valid <= 1'b1;
                        llr_last  <= last_half;
                        state     <= OUT;
                    end
                    OUT: if (llr_valid && llr_ready) begin
                        llr_valid  <= 1'b0;
                        llr_last   <= 1'b0;
                        cnt        <= '0;
                        core_rst_n <= 1'b0;
                        if (last_half) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            dec_sel  <= !dec_sel;
                            iter_idx <= dec_sel ? iter_idx + 4'd1 : iter_idx;
                            state    <= CORE_RST;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sova_iter_sched.sv
// tb_sova_iter_sched: directed cycle-level checks of the SOVA iteration scheduler
module tb_sova_iter_sched;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, llr_ready = 1'b1;
    logic [3:0]  num_iter = 4'd0;
    logic [30:0] soft_in1 = 31'h4000_0005, soft_in2 = 31'h0000_0003;
    logic [30:0] soft_in3 = 31'h4000_0001, soft_in4 = 31'h3FFF_FFFF;
    logic [30:0] llr_out1, llr_out2, llr_out3, llr_out4, soft_base;
    logic        busy, core_rst_n, dec_sel, llr_valid, llr_last, done;
    logic [3:0]  iter_idx, hard_bits;

    sova_iter_sched dut (
        .clk(clk), .rst(rst), .start(start), .num_iter(num_iter), .abort(abort),
        .busy(busy), .core_rst_n(core_rst_n), .dec_sel(dec_sel), .iter_idx(iter_idx),
        .soft_in1(soft_in1), .soft_in2(soft_in2), .soft_in3(soft_in3), .soft_in4(soft_in4),
        .llr_out1(llr_out1), .llr_out2(llr_out2), .llr_out3(llr_out3), .llr_out4(llr_out4),
        .hard_bits(hard_bits), .llr_valid(llr_valid), .llr_ready(llr_ready),
        .llr_last(llr_last), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_miss = 0;
    int hs_cyc[$], low_start[$];
    logic hs_dec[$], hs_last[$];
    logic [3:0] hs_iter[$], hs_hb[$];
    logic [30:0] hs_l1[$], hs_l4[$];
    int low_cnt, first_high, done_cyc, stable_bad;
    logic first_busy, busy_at_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] ni, input int stall, input int abort_at, input int rst_at, input int bstart_at);
        int stall_left;
        logic prev_crn, prev_valid, stalling;
        logic [30:0] prev_l1;
        stall_left = stall; prev_crn = 1'b1; prev_valid = 1'b0; prev_l1 = '0;
        hs_cyc.delete(); low_start.delete(); hs_dec.delete(); hs_last.delete();
        hs_iter.delete(); hs_hb.delete(); hs_l1.delete(); hs_l4.delete();
        low_cnt = 0; first_high = -1; done_cyc = -1; stable_bad = 0;
        first_busy = 1'b0; busy_at_done = 1'b1;
        num_iter = ni; start = 1'b1; llr_ready = 1'b1; soft_in1 = soft_base;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 1200; c++) begin
            if (c == abort_at + 1 || c == rst_at + 1) break;
            if (!core_rst_n && busy && (c == 1 || prev_crn)) low_start.push_back(c);
            if (!core_rst_n && busy) low_cnt++;
            if (c == 1) first_busy = busy;
            if (core_rst_n && first_high < 0) first_high = c;
            if (llr_valid && prev_valid && llr_out1 != prev_l1) stable_bad++;
            prev_crn = core_rst_n; prev_valid = llr_valid; prev_l1 = llr_out1;
            if (done) begin
                done_cyc = c; busy_at_done = busy;
                break;
            end
            stalling = llr_valid && stall_left > 0;
            llr_ready = !stalling;
            soft_in1 = stalling ? 31'h0123_4567 : soft_base;
            if (stalling) stall_left--;
            if (llr_valid && llr_ready) begin
                hs_cyc.push_back(c); hs_dec.push_back(dec_sel); hs_last.push_back(llr_last);
                hs_iter.push_back(iter_idx); hs_hb.push_back(hard_bits);
                hs_l1.push_back(llr_out1); hs_l4.push_back(llr_out4);
            end
            abort = (c == abort_at);
            rst = !(c == rst_at);
            start = (c == bstart_at);
            @(posedge clk); #1;
        end
        abort = 1'b0; rst = 1'b1; start = 1'b0; llr_ready = 1'b1; soft_in1 = soft_base;
    endtask

    initial begin
        int cnt;
        logic [31:0] seq;
        soft_base = 31'h4000_0005;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {busy, core_rst_n, dec_sel, iter_idx, llr_valid, llr_last, done, hard_bits}, 0);
        chk("rst_llr", {1'b0, llr_out1 | llr_out2 | llr_out3 | llr_out4}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run(4'd1, 0, -9, -9, 10);
        chk("a_hs_n", hs_cyc.size(), 2);
        chk("a_hs0_cyc", hs_cyc[0], 32);
        chk("a_hs1_cyc", hs_cyc[1], 64);
        chk("a_dec", {hs_dec[0], hs_dec[1]}, 2'b01);
        chk("a_last", {hs_last[0], hs_last[1]}, 2'b01);
        chk("a_done_cyc", done_cyc, 65);
        chk("a_busy_done", busy_at_done, 0);
        chk("a_busy_c1", first_busy, 1);
        chk("a_crn_low0", low_start[0], 1);
        chk("a_crn_high", first_high, 3);
        chk("a_crn_low1", low_start[1], 33);
        chk("a_crn_cnt", low_cnt, 4);

        run(4'd3, 0, -9, -9, -9);
        chk("b_hs_n", hs_cyc.size(), 6);
        seq = 0; cnt = 0;
        foreach (hs_iter[i]) begin
            seq = (seq << 4) | 32'(hs_iter[i]);
            if (hs_l1[i] == 31'h4000_0005 && hs_hb[i] == 4'b0101) cnt++;
        end
        chk("b_iter_seq", seq, 32'h0000_1122);
        chk("b_capture", cnt, 6);
        chk("b_llr4", {1'b0, hs_l4[0]}, 32'h3FFF_FFFF);
        chk("b_last", {hs_last[4], hs_last[5]}, 2'b01);
        chk("b_done_cyc", done_cyc, 193);

        run(4'd1, 10, -9, -9, -9);
        chk("c_hs0_cyc", hs_cyc[0], 42);
        chk("c_stable", stable_bad, 0);
        chk("c_l1_hold", {1'b0, hs_l1[0]}, 32'h4000_0005);
        chk("c_crn_low1", low_start[1], 43);
        chk("c_hs1_cyc", hs_cyc[1], 74);
        chk("c_done_cyc", done_cyc, 75);

        run(4'd0, 0, -9, -9, -9);
        chk("d0_hs_n", hs_cyc.size(), 2);
        chk("d0_done_cyc", done_cyc, 65);
        run(4'd15, 0, -9, -9, -9);
        chk("d15_hs_n", hs_cyc.size(), 16);
        chk("d15_last_iter", hs_iter[15], 7);
        chk("d15_done_cyc", done_cyc, 513);

        run(4'd2, 0, 40, -9, -9);
        chk("e_hs_n", hs_cyc.size(), 1);
        chk("e_abort_out", {busy, core_rst_n, llr_valid, done}, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy || llr_valid) cnt++;
        end
        chk("e_quiet", cnt, 0);
        run(4'd1, 0, -9, -9, -9);
        chk("e_restart_done", done_cyc, 65);

        run(4'd2, 0, -9, 128, -9);
        chk("f_pre_hs_n", hs_cyc.size(), 4);
        chk("f_rst_ctrl", {busy, core_rst_n, dec_sel, iter_idx, llr_valid, llr_last, done, hard_bits}, 0);
        chk("f_rst_llr", {1'b0, llr_out1 | llr_out2 | llr_out3 | llr_out4}, 0);
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; num_iter = 4'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("g_abort_start", {busy, core_rst_n}, 0);
        @(posedge clk); #1;
        chk("g_still_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
